// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared state encoding, defaults and helpers for the PC sequencer.
// Optional fetch timeout is enabled with the PC_FETCH_TIMEOUT_EN macro.
package pc_ctrl_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
    localparam int unsigned CNT_W_DEF          = 32;

    // FAULT only exists when the fetch timeout feature is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
`ifdef PC_FETCH_TIMEOUT_EN
        ST_UPDATE = 3'd4,
        ST_FAULT  = 3'd5
`else
        ST_UPDATE = 3'd4
`endif
    } pc_state_t;

    // A taken branch (branch flag with zero result) overrides a jump.
    function automatic logic jmp_qualify(input logic br_f, input logic z_f, input logic jmp_f);
        return jmp_f & ~(br_f & z_f);
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_fetch_timer.sv
// fetch_timer: counts FETCH cycles and flags the cycle in which the limit is hit.
// Only compiled and used when PC_FETCH_TIMEOUT_EN is defined.
`ifdef PC_FETCH_TIMEOUT_EN
module fetch_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] r_cnt;

    // Counter is held at zero while loading and advances once per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // The LIMIT-th enabled cycle after a load is the expiry cycle.
    assign o_expire = i_en & ~i_load & (r_cnt == W'(LIMIT - 1));

endmodule
`endif

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multicycle FETCH/DECODE/EXEC/UPDATE sequencer driving the PC block.
// Define PC_FETCH_TIMEOUT_EN to add the fetch timeout, FAULT state and sticky fault flag.
module pc_seq_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             clr_req,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    input  logic             dec_branch,
    input  logic             dec_jmp,
    input  logic             exe_done,
    input  logic             alu_zero,
    output logic             pc_en,
    output logic             pc_branch,
    output logic             pc_zero,
    output logic             pc_jmp,
    output logic             pc_clr,
    output logic             busy,
    output logic [CNT_W-1:0] retired,
    output logic             fault
);

    if (TIMEOUT_CYCLES < 2 || CNT_W < 1) begin : g_param_chk
        $error("pc_seq_ctrl: TIMEOUT_CYCLES must be >= 2 and CNT_W >= 1");
    end

    pc_state_t        r_state;
    pc_state_t        w_state_nxt;
    logic             r_br_f;
    logic             r_jmp_f;
    logic             r_z_f;
    logic [CNT_W-1:0] r_retired;
    logic             w_timeout;
    logic             w_upd;

`ifdef PC_FETCH_TIMEOUT_EN
    logic w_flush;
    logic w_tmr_load;
    logic w_tmr_en;
    logic w_tmr_expire;
    logic r_fault;

    assign w_flush    = clr_req & (r_state != ST_IDLE);
    // Reloading outside FETCH (and on a flush) restarts the count on each FETCH entry.
    assign w_tmr_load = (r_state != ST_FETCH) | clr_req;
    assign w_tmr_en   = (r_state == ST_FETCH);

    fetch_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_fetch_timer (
        .clk      (clk),
        .rst_n    (rst),
        .i_load   (w_tmr_load),
        .i_en     (w_tmr_en),
        .o_expire (w_tmr_expire)
    );

    // An ack or a flush in the expiry cycle wins over the timeout.
    assign w_timeout = w_tmr_expire & ~imem_ack & ~clr_req;

    // Sticky fault flag: set on timeout, cleared only by reset or a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault <= 1'b0;
        end else if (w_flush) begin
            r_fault <= 1'b0;
        end else if (w_timeout) begin
            r_fault <= 1'b1;
        end else begin
            r_fault <= r_fault;
        end
    end

    assign fault = r_fault;
`else
    assign w_timeout = 1'b0;
    assign fault     = 1'b0;
`endif

    // Next-state logic; a flush in any active state restarts fetching.
    always_comb begin
        w_state_nxt = r_state;
        if (clr_req && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_FETCH;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) w_state_nxt = ST_FETCH;
                    else       w_state_nxt = ST_IDLE;
                end
                ST_FETCH: begin
                    if (imem_ack) w_state_nxt = ST_DECODE;
`ifdef PC_FETCH_TIMEOUT_EN
                    else if (w_timeout) w_state_nxt = ST_FAULT;
`endif
                    else w_state_nxt = ST_FETCH;
                end
                ST_DECODE: w_state_nxt = ST_EXEC;
                ST_EXEC: begin
                    if (exe_done) w_state_nxt = ST_UPDATE;
                    else          w_state_nxt = ST_EXEC;
                end
                ST_UPDATE: begin
                    if (halt) w_state_nxt = ST_IDLE;
                    else      w_state_nxt = ST_FETCH;
                end
`ifdef PC_FETCH_TIMEOUT_EN
                ST_FAULT: w_state_nxt = ST_FAULT;
`endif
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Branch/jump/zero flags captured along the instruction, dropped on a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_br_f  <= 1'b0;
            r_jmp_f <= 1'b0;
            r_z_f   <= 1'b0;
        end else if (clr_req) begin
            r_br_f  <= 1'b0;
            r_jmp_f <= 1'b0;
            r_z_f   <= 1'b0;
        end else begin
            if (r_state == ST_DECODE) begin
                r_br_f  <= dec_branch;
                r_jmp_f <= dec_jmp;
            end
            if ((r_state == ST_EXEC) && exe_done) begin
                r_z_f <= alu_zero;
            end
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retired <= '0;
        end else if ((r_state == ST_UPDATE) && !clr_req) begin
            r_retired <= r_retired + CNT_W'(1);
        end else begin
            r_retired <= r_retired;
        end
    end

    // Strobes decode the registered state; a flush suppresses everything but pc_clr.
    assign w_upd     = (r_state == ST_UPDATE) & ~clr_req;
    assign imem_req  = (r_state == ST_FETCH) & ~clr_req;
    assign ir_load   = (r_state == ST_FETCH) & imem_ack & ~clr_req;
    assign pc_en     = w_upd;
    assign pc_branch = w_upd & r_br_f;
    assign pc_zero   = w_upd & r_z_f;
    assign pc_jmp    = w_upd & jmp_qualify(r_br_f, r_z_f, r_jmp_f);
    assign pc_clr    = rst & (clr_req | w_timeout);
    assign busy      = (r_state != ST_IDLE);
    assign retired   = r_retired;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed-vector bench for pc_seq_ctrl (CNT_W=4, TIMEOUT_CYCLES=16).
// Timeout scenario is compiled when PC_FETCH_TIMEOUT_EN is defined.
module tb_pc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, halt, clr_req, imem_ack, dec_branch, dec_jmp, exe_done, alu_zero;
    logic       imem_req, ir_load, pc_en, pc_branch, pc_zero, pc_jmp, pc_clr, busy, fault;
    logic [3:0] retired;
    logic [7:0] obs;

    int n_vec = 0;
    int n_err = 0;
    int n_en  = 0;

    pc_seq_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clr_req(clr_req),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
        .dec_branch(dec_branch), .dec_jmp(dec_jmp), .exe_done(exe_done), .alu_zero(alu_zero),
        .pc_en(pc_en), .pc_branch(pc_branch), .pc_zero(pc_zero), .pc_jmp(pc_jmp),
        .pc_clr(pc_clr), .busy(busy), .retired(retired), .fault(fault)
    );

    // obs bit order: imem_req ir_load pc_en pc_branch pc_zero pc_jmp pc_clr busy
    assign obs = {imem_req, ir_load, pc_en, pc_branch, pc_zero, pc_jmp, pc_clr, busy};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; halt = 1'b0; clr_req = 1'b0; imem_ack = 1'b0;
        dec_branch = 1'b0; dec_jmp = 1'b0; exe_done = 1'b0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (obs !== 8'b0000_0000) begin n_err++; $display("FAIL reset_obs got=%b exp=%b", obs, 8'b0000_0000); end
        n_vec++; if (retired !== 4'd0) begin n_err++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", fault); end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        start = 1'b1; #1;
        n_vec++; if (obs !== 8'b0000_0000) begin n_err++; $display("FAIL basic_idle got=%b exp=%b", obs, 8'b0000_0000); end
        tick(); start = 1'b0; imem_ack = 1'b1; #1;
        n_vec++; if (obs !== 8'b1100_0001) begin n_err++; $display("FAIL basic_fetch got=%b exp=%b", obs, 8'b1100_0001); end
        tick(); imem_ack = 1'b0; #1;
        n_vec++; if (obs !== 8'b0000_0001) begin n_err++; $display("FAIL basic_decode got=%b exp=%b", obs, 8'b0000_0001); end
        tick(); exe_done = 1'b1; alu_zero = 1'b0; #1;
        n_vec++; if (obs !== 8'b0000_0001) begin n_err++; $display("FAIL basic_exec got=%b exp=%b", obs, 8'b0000_0001); end
        tick(); exe_done = 1'b0; halt = 1'b1; #1;
        n_vec++; if (obs !== 8'b0010_0001) begin n_err++; $display("FAIL basic_update got=%b exp=%b", obs, 8'b0010_0001); end
        n_vec++; if (retired !== 4'd0) begin n_err++; $display("FAIL basic_ret_pre got=%0d exp=0", retired); end
        tick(); halt = 1'b0; #1;
        n_vec++; if (obs !== 8'b0000_0000) begin n_err++; $display("FAIL basic_halt_idle got=%b exp=%b", obs, 8'b0000_0000); end
        n_vec++; if (retired !== 4'd1) begin n_err++; $display("FAIL basic_retired got=%0d exp=1", retired); end
    endtask

    task automatic test_taken_branch();
        start = 1'b1; tick();
        start = 1'b0; imem_ack = 1'b1; tick();
        imem_ack = 1'b0; dec_branch = 1'b1; dec_jmp = 1'b1; tick();
        dec_branch = 1'b0; dec_jmp = 1'b0; exe_done = 1'b1; alu_zero = 1'b1; tick();
        exe_done = 1'b0; alu_zero = 1'b0; halt = 1'b1; #1;
        n_vec++; if (obs !== 8'b0011_1001) begin n_err++; $display("FAIL taken_update got=%b exp=%b", obs, 8'b0011_1001); end
        tick(); halt = 1'b0; #1;
        n_vec++; if (obs !== 8'b0000_0000) begin n_err++; $display("FAIL taken_after got=%b exp=%b", obs, 8'b0000_0000); end
        n_vec++; if (retired !== 4'd2) begin n_err++; $display("FAIL taken_retired got=%0d exp=2", retired); end
    endtask

    task automatic test_untaken_jump_slow_ack();
        start = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (obs !== 8'b1000_0001) begin n_err++; $display("FAIL slow_fetch_wait%0d got=%b exp=%b", i, obs, 8'b1000_0001); end
            tick();
        end
        imem_ack = 1'b1; #1;
        n_vec++; if (obs !== 8'b1100_0001) begin n_err++; $display("FAIL slow_fetch_ack got=%b exp=%b", obs, 8'b1100_0001); end
        tick(); imem_ack = 1'b0; dec_branch = 1'b1; dec_jmp = 1'b1; tick();
        dec_branch = 1'b0; dec_jmp = 1'b0; start = 1'b1; #1;
        n_vec++; if (obs !== 8'b0000_0001) begin n_err++; $display("FAIL slow_exec_wait got=%b exp=%b", obs, 8'b0000_0001); end
        tick(); start = 1'b0; exe_done = 1'b1; alu_zero = 1'b0; #1;
        n_vec++; if (obs !== 8'b0000_0001) begin n_err++; $display("FAIL slow_start_ignored got=%b exp=%b", obs, 8'b0000_0001); end
        tick(); exe_done = 1'b0; halt = 1'b1; #1;
        n_vec++; if (obs !== 8'b0011_0101) begin n_err++; $display("FAIL untaken_update got=%b exp=%b", obs, 8'b0011_0101); end
        tick(); halt = 1'b0; #1;
        n_vec++; if (retired !== 4'd3) begin n_err++; $display("FAIL untaken_retired got=%0d exp=3", retired); end
    endtask

    task automatic test_flush();
        start = 1'b1; tick();
        start = 1'b0; imem_ack = 1'b1; tick();
        imem_ack = 1'b0; tick();
        exe_done = 1'b1; alu_zero = 1'b1; clr_req = 1'b1; halt = 1'b1; #1;
        n_vec++; if (obs !== 8'b0000_0011) begin n_err++; $display("FAIL flush_exec got=%b exp=%b", obs, 8'b0000_0011); end
        tick(); exe_done = 1'b0; alu_zero = 1'b0; clr_req = 1'b0; halt = 1'b0; #1;
        n_vec++; if (obs !== 8'b1000_0001) begin n_err++; $display("FAIL flush_refetch got=%b exp=%b", obs, 8'b1000_0001); end
        n_vec++; if (retired !== 4'd3) begin n_err++; $display("FAIL flush_no_retire got=%0d exp=3", retired); end
        imem_ack = 1'b1; tick();
        imem_ack = 1'b0; tick();
        exe_done = 1'b1; tick();
        exe_done = 1'b0; halt = 1'b1; #1;
        n_vec++; if (obs !== 8'b0010_0001) begin n_err++; $display("FAIL flush_next_update got=%b exp=%b", obs, 8'b0010_0001); end
        tick(); halt = 1'b0; #1;
        n_vec++; if (obs !== 8'b0000_0000) begin n_err++; $display("FAIL halt_idle got=%b exp=%b", obs, 8'b0000_0000); end
        n_vec++; if (retired !== 4'd4) begin n_err++; $display("FAIL flush_retired got=%0d exp=4", retired); end
        clr_req = 1'b1; #1;
        n_vec++; if (obs !== 8'b0000_0010) begin n_err++; $display("FAIL idle_clr got=%b exp=%b", obs, 8'b0000_0010); end
        tick(); clr_req = 1'b0; #1;
        n_vec++; if (obs !== 8'b0000_0000) begin n_err++; $display("FAIL idle_clr_stay got=%b exp=%b", obs, 8'b0000_0000); end
    endtask

    task automatic test_async_reset();
        start = 1'b1; tick();
        start = 1'b0; #1;
        n_vec++; if (obs !== 8'b1000_0001) begin n_err++; $display("FAIL arst_fetch got=%b exp=%b", obs, 8'b1000_0001); end
        #2; rst = 1'b0; #1;
        n_vec++; if (obs !== 8'b0000_0000) begin n_err++; $display("FAIL arst_drop got=%b exp=%b", obs, 8'b0000_0000); end
        n_vec++; if (retired !== 4'd0) begin n_err++; $display("FAIL arst_retired got=%0d exp=0", retired); end
        tick(); rst = 1'b1;
    endtask

    task automatic test_wrap();
        n_en = 0;
        start = 1'b1; tick();
        start = 1'b0;
        for (int k = 0; k < 17; k++) begin
            imem_ack = 1'b1; #1; n_en += int'(pc_en); tick();
            imem_ack = 1'b0; #1; n_en += int'(pc_en); tick();
            exe_done = 1'b1; #1; n_en += int'(pc_en); tick();
            exe_done = 1'b0; halt = (k == 16); #1; n_en += int'(pc_en); tick();
        end
        halt = 1'b0; #1;
        n_vec++; if (retired !== 4'd1) begin n_err++; $display("FAIL wrap_retired got=%0d exp=1", retired); end
        n_vec++; if (n_en !== 17) begin n_err++; $display("FAIL wrap_pc_en_count got=%0d exp=17", n_en); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrap_busy got=%b exp=0", busy); end
    endtask

`ifdef PC_FETCH_TIMEOUT_EN
    task automatic test_timeout();
        start = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            n_vec++; if (obs !== 8'b1000_0001) begin n_err++; $display("FAIL to_wait%0d got=%b exp=%b", i, obs, 8'b1000_0001); end
            tick();
        end
        #1;
        n_vec++; if (obs !== 8'b1000_0011) begin n_err++; $display("FAIL to_expire got=%b exp=%b", obs, 8'b1000_0011); end
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL to_fault_pre got=%b exp=0", fault); end
        tick(); #1;
        n_vec++; if (obs !== 8'b0000_0001) begin n_err++; $display("FAIL to_fault_obs got=%b exp=%b", obs, 8'b0000_0001); end
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL to_fault_set got=%b exp=1", fault); end
        start = 1'b1; tick(); start = 1'b0; #1;
        n_vec++; if (obs !== 8'b0000_0001) begin n_err++; $display("FAIL to_start_ignored got=%b exp=%b", obs, 8'b0000_0001); end
        n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL to_fault_sticky got=%b exp=1", fault); end
        clr_req = 1'b1; #1;
        n_vec++; if (obs !== 8'b0000_0011) begin n_err++; $display("FAIL to_clr got=%b exp=%b", obs, 8'b0000_0011); end
        tick(); clr_req = 1'b0; #1;
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL to_fault_clear got=%b exp=0", fault); end
        n_vec++; if (obs !== 8'b1000_0001) begin n_err++; $display("FAIL to_refetch got=%b exp=%b", obs, 8'b1000_0001); end
        rst = 1'b0; #1;
        n_vec++; if (obs !== 8'b0000_0000) begin n_err++; $display("FAIL to_arst got=%b exp=%b", obs, 8'b0000_0000); end
        tick(); rst = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_taken_branch();
        test_untaken_jump_slow_ack();
        test_flush();
        test_async_reset();
        test_wrap();
`ifdef PC_FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Multicycle sequencer for the program counter. It walks each instruction through fetch, decode, execute and PC update. It handshakes with instruction memory, qualifies the decoder's branch/jump requests with the ALU zero flag, and issues exactly one PC update per retired instruction. It sits between the decoder/ALU and the `pc` block and drives that block's `branch`, `zero`, `jmp` and `clr` inputs plus a PC-advance enable.

## Interface
- `TIMEOUT_CYCLES`, 16: consecutive FETCH cycles without `imem_ack` before fault; only used with `PC_FETCH_TIMEOUT_EN`.
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE and begin fetching.
- `halt`  in  1  return to IDLE at the next UPDATE.
- `clr_req`  in  1  flush request, clear PC and restart fetch.
- `imem_req`  out  1  instruction memory read request.
- `imem_ack`  in  1  instruction word valid this cycle.
- `ir_load`  out  1  capture instruction register.
- `dec_branch`  in  1  decoder branch flag, sampled in DECODE.
- `dec_jmp`  in  1  decoder jump flag, sampled in DECODE.
- `exe_done`  in  1  execute complete; `alu_zero` valid.
- `alu_zero`  in  1  ALU zero flag, sampled with `exe_done`.
- `pc_en`  out  1  PC advance/load strobe.
- `pc_branch`  out  1  to PC `branch`.
- `pc_zero`  out  1  to PC `zero`.
- `pc_jmp`  out  1  to PC `jmp`.
- `pc_clr`  out  1  to PC `clr`.
- `busy`  out  1  state != IDLE.
- `retired`  out  CNT_W  count of completed UPDATE cycles.
- `fault`  out  1  sticky fetch-timeout flag; tied 0 without the macro.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, FAULT (FAULT exists only with the macro).
- IDLE: all strobes 0. `start`=1 moves to FETCH. `halt` has no effect here.
- FETCH: `imem_req`=1 every cycle until ack. `ir_load` = `imem_ack` (Mealy). On ack, go to DECODE.
- DECODE: 1 cycle. Latch `br_f`=`dec_branch` and `jmp_f`=`dec_jmp`. Go to EXEC.
- EXEC: wait for `exe_done`. On `exe_done`, latch `z_f`=`alu_zero` and go to UPDATE.
- UPDATE: 1 cycle with `pc_en`=1, `pc_branch`=`br_f`, `pc_zero`=`z_f`, `pc_jmp`=`jmp_f` & ~(`br_f`&`z_f`). A taken branch has priority over a jump. `retired` increments and wraps at 2^CNT_W. Next state is IDLE if `halt`, otherwise FETCH.
- `pc_branch`, `pc_zero` and `pc_jmp` are 0 outside UPDATE.
- `clr_req` in any non-IDLE state:
  - `pc_clr`=1 that cycle, all other strobes 0, flags cleared.
  - Next state is FETCH.
  - Beats `halt`, `imem_ack` and `exe_done` in the same cycle; the instruction is not retired.
- `clr_req` in IDLE: `pc_clr` pulses and the state stays IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset: state IDLE. All outputs 0. `retired`=0, `fault`=0, flags 0. Reset takes effect immediately and asynchronously, including mid-FETCH; `imem_req` drops with it.
- Minimum instruction latency is 4 cycles (FETCH, DECODE, EXEC, UPDATE) with same-cycle ack and `exe_done`.
- `pc_en` is a single-cycle pulse, exactly one per retired instruction.
- Every strobe except `ir_load` and `pc_clr` is a registered-state decode.

## Configuration
- `PC_FETCH_TIMEOUT_EN` defined:
  - A counter runs during FETCH and resets on entry to FETCH.
  - When it reaches `TIMEOUT_CYCLES` without ack: enter FAULT, set `fault`=1 (sticky), and pulse `pc_clr` for 1 cycle.
  - FAULT drives no strobes and ignores `start`.
  - FAULT exits only on `rst` or `clr_req` (to FETCH, clearing `fault`).
- Not defined: FETCH waits indefinitely. No counter logic, `fault` tied 0, FAULT state absent.

## Structure
- `pc_ctrl_pkg`: state enum typedef `pc_state_t` (3-bit encoding) and default constants for `TIMEOUT_CYCLES` and `CNT_W`.
- Sub-module `fetch_timer`: load/enable/expire counter, instantiated only under the macro.

## Test plan
- Basic instruction: reset, `start`, ack in 1st FETCH cycle, `exe_done` at once, no branch/jump -> `pc_en` pulse 4 cycles after `start`, `pc_branch`=`pc_jmp`=0, `retired`=1.
- Taken branch: `dec_branch`=1, `alu_zero`=1 with `exe_done`, `dec_jmp`=1 -> UPDATE drives `pc_branch`=1, `pc_zero`=1, `pc_jmp`=0.
- Untaken branch plus jump: `dec_branch`=1, `alu_zero`=0, `dec_jmp`=1 -> `pc_jmp`=1. Also ack delayed 3 cycles -> `imem_req` high for 4 cycles, `ir_load` only on the ack cycle.
- Flush vs. completion: `clr_req` and `exe_done` in the same EXEC cycle -> `pc_clr`=1, no `pc_en`, `retired` unchanged, next state FETCH. Also `halt` in UPDATE -> IDLE, `busy`=0.
- Wrap: `CNT_W`=4, retire 17 instructions -> `retired`=1.
- Timeout (`PC_FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): no ack -> after 16 FETCH cycles `fault`=1 with a 1-cycle `pc_clr`. `start` is then ignored. `clr_req` clears `fault` and returns to FETCH. Async `rst` mid-FETCH drops `imem_req` immediately.
